// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
// State encoding, default widths and control-bundle field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_CNT_W = 8;

  // RegWrite / ResultSrc bundle layout
  localparam int RW_BIT = 0;
  localparam int RS_LSB = 1;
  localparam int RS_W   = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating counter, adds 0..3 per cycle, sticks at all-ones.
// Ports: clock, reset (async high), i_inc[1:0], o_cnt[CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_nxt;

  // one extra bit catches overflow; inc<=3 cannot wrap it
  assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(i_inc);
  assign w_nxt = w_sum[CNT_W] ? {CNT_W{1'b1}}
                              : w_sum[CNT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Reusable control/payload stage register with valid/ready,
// optional skid entry, flush with bubble zeroing, flush counter.
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SKID  = 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           r_state;
  state_t           w_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [1:0]       w_held;
  logic [1:0]       w_inc;

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = r_ready;
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    w_nxt      = r_state;
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    if (flush) begin
      w_nxt      = EMPTY;
      w_main_nxt = '0;
      w_skid_nxt = '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_nxt      = ONE;
            w_main_nxt = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            (w_in_xfer && w_out_xfer): begin
              w_main_nxt = in_data;
            end
            (w_in_xfer && !w_out_xfer): begin
              w_nxt      = TWO;
              w_skid_nxt = in_data;
            end
            (!w_in_xfer && w_out_xfer): begin
              w_nxt      = EMPTY;
              w_main_nxt = '0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (w_out_xfer) begin
            w_nxt      = ONE;
            w_main_nxt = r_skid;
            w_skid_nxt = '0;
          end
        end
        default: begin
          w_nxt      = EMPTY;
          w_main_nxt = '0;
          w_skid_nxt = '0;
        end
      endcase
    end
  end

  // live entries lost to a flush, plus a same-cycle input
  assign w_held = (r_state == TWO) ? 2'd2 :
                  (r_state == ONE) ? 2'd1 : 2'd0;
  assign w_inc  = flush ? (w_held + {1'b0, w_in_xfer}) : 2'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_ready <= (w_nxt != TWO);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .i_inc (w_inc),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench for pipe_ctrl_stage: skid, saturation and
// no-skid instances share stimulus; each task checks one.
module tb_pipe_ctrl_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [2:0] in_data;
  logic       out_ready;

  logic       ir_a, ov_a;
  logic [2:0] od_a;
  logic [7:0] fc_a;
  logic       ir_s, ov_s;
  logic [2:0] od_s;
  logic [1:0] fc_s;
  logic       ir_z, ov_z;
  logic [2:0] od_z;
  logic [7:0] fc_z;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipe_ctrl_stage #(.WIDTH(3), .SKID(1), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .flush_cnt(fc_a)
  );

  pipe_ctrl_stage #(.WIDTH(3), .SKID(1), .CNT_W(2)) u_s (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .flush_cnt(fc_s)
  );

  pipe_ctrl_stage #(.WIDTH(3), .SKID(0), .CNT_W(8)) u_z (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_z), .in_data(in_data),
    .out_valid(ov_z), .out_ready(out_ready), .out_data(od_z),
    .flush_cnt(fc_z)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    flush = 1'b0; in_valid = 1'b0; in_data = 3'd0;
    out_ready = 1'b0; reset = 1'b1;
    step; step;
    reset = 1'b0;
    #1;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_out: valid=%b data=%h want 0/0", ov_a, od_a);
    end
    n_chk++;
    if (fc_a !== 8'd0 || ir_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_misc: cnt=%0d rdy=%b want 0/1", fc_a, ir_a);
    end
    n_chk++;
    if (ir_z !== 1'b1 || ov_z !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_z: rdy=%b valid=%b want 1/0", ir_z, ov_z);
    end
    in_valid = 1'b1; in_data = 3'h5;
    step;
    in_valid = 1'b0;
    n_chk++;
    if (od_a !== 3'h5 || ov_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_hold: data=%h valid=%b want 5/1", od_a, ov_a);
    end
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0 || ir_a !== 1'b1
        || fc_a !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_async: v=%b d=%h r=%b c=%0d want 0/0/1/0",
               ov_a, od_a, ir_a, fc_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream;
    logic [2:0] vec [3];
    vec[0] = 3'h5; vec[1] = 3'h3; vec[2] = 3'h7;
    do_reset;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = vec[k];
      step;
      n_chk++;
      if (od_a !== vec[k] || ov_a !== 1'b1 || ir_a !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: d=%h v=%b r=%b want %h/1/1",
                 k, od_a, ov_a, ir_a, vec[k]);
      end
    end
    in_valid = 1'b0;
    step;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_end: v=%b d=%h want 0/0", ov_a, od_a);
    end
  endtask

  task automatic fill_two;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'h1;
    step;
    in_data = 3'h2;
    step;
    in_valid = 1'b0;
  endtask

  task automatic test_skid_fill;
    do_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'h1;
    step;
    in_data = 3'h2;
    n_chk++;
    if (ir_a !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_rdy1: rdy=%b want 1", ir_a);
    end
    step;
    in_valid = 1'b0;
    n_chk++;
    if (ir_a !== 1'b0 || od_a !== 3'h1 || ov_a !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_two: r=%b d=%h v=%b want 0/1/1",
               ir_a, od_a, ov_a);
    end
    out_ready = 1'b1;
    step;
    n_chk++;
    if (od_a !== 3'h2 || ir_a !== 1'b1 || ov_a !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_drain: d=%h r=%b v=%b want 2/1/1",
               od_a, ir_a, ov_a);
    end
    step;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0) begin
      n_fail++;
      $display("FAIL skid_empty: v=%b d=%h want 0/0", ov_a, od_a);
    end
  endtask

  task automatic test_flush_two;
    do_reset;
    fill_two;
    in_valid = 1'b1; in_data = 3'h4; flush = 1'b1;
    n_chk++;
    if (ir_a !== 1'b0) begin
      n_fail++;
      $display("FAIL flush2_rdy: rdy=%b want 0", ir_a);
    end
    step;
    flush = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0 || fc_a !== 8'd2) begin
      n_fail++;
      $display("FAIL flush2: v=%b d=%h c=%0d want 0/0/2",
               ov_a, od_a, fc_a);
    end
  endtask

  task automatic test_flush_input;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'h5;
    step;
    in_data = 3'h6; flush = 1'b1;
    step;
    in_valid = 1'b0;
    n_chk++;
    if (ov_a !== 1'b0 || od_a !== 3'd0 || fc_a !== 8'd4) begin
      n_fail++;
      $display("FAIL flush_in: v=%b d=%h c=%0d want 0/0/4",
               ov_a, od_a, fc_a);
    end
    step;
    flush = 1'b0;
    n_chk++;
    if (fc_a !== 8'd4 || ov_a !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: c=%0d v=%b want 4/0", fc_a, ov_a);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp [3];
    exp[0] = 2'd2; exp[1] = 2'd3; exp[2] = 2'd3;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      fill_two;
      flush = 1'b1;
      step;
      flush = 1'b0;
      n_chk++;
      if (fc_s !== exp[k]) begin
        n_fail++;
        $display("FAIL sat[%0d]: cnt=%0d want %0d", k, fc_s, exp[k]);
      end
    end
  endtask

  task automatic test_noskid_ready;
    do_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'h5;
    step;
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (ov_z !== 1'b1 || ir_z !== 1'b0 || od_z !== 3'h5) begin
      n_fail++;
      $display("FAIL z_stall: v=%b r=%b d=%h want 1/0/5",
               ov_z, ir_z, od_z);
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (ir_z !== 1'b1) begin
      n_fail++;
      $display("FAIL z_comb_rdy: rdy=%b want 1", ir_z);
    end
    step;
  endtask

  task automatic test_random;
    logic [2:0] qz [$];
    logic [2:0] qa [$];
    logic [2:0] e;
    int nout = 0;
    do_reset;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom);
      in_data   = 3'($urandom);
      out_ready = 1'($urandom);
      @(negedge clock);
      if (!ov_z) begin
        n_chk++;
        if (od_z !== 3'd0) begin
          n_fail++;
          $display("FAIL rnd_z_bubble@%0d: d=%h want 0", c, od_z);
        end
      end else if (out_ready) begin
        n_chk++;
        if (qz.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_z_extra@%0d: d=%h want none", c, od_z);
        end else begin
          e = qz.pop_front();
          nout++;
          if (od_z !== e) begin
            n_fail++;
            $display("FAIL rnd_z@%0d: d=%h want %h", c, od_z, e);
          end
        end
      end
      if (in_valid && ir_z) qz.push_back(in_data);
      if (!ov_a) begin
        n_chk++;
        if (od_a !== 3'd0) begin
          n_fail++;
          $display("FAIL rnd_a_bubble@%0d: d=%h want 0", c, od_a);
        end
      end else if (out_ready) begin
        n_chk++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_a_extra@%0d: d=%h want none", c, od_a);
        end else begin
          e = qa.pop_front();
          if (od_a !== e) begin
            n_fail++;
            $display("FAIL rnd_a@%0d: d=%h want %h", c, od_a, e);
          end
        end
      end
      if (in_valid && ir_a) qa.push_back(in_data);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    n_chk++;
    if (nout < 1000) begin
      n_fail++;
      $display("FAIL rnd_progress: outputs=%0d want >=1000", nout);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_skid_fill;
    test_flush_two;
    test_flush_input;
    test_saturation;
    test_noskid_ready;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
